// File: rtl/program_counter_pkg.sv
// Shared widths and reset constant for the program counter, address calculator and stack pointer.
package program_counter_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_VECTOR = 16'h0000;

endpackage

// File: rtl/program_counter_bus_driver.sv
// Parameterised-width tri-state buffer; drives d onto q while en_n is low, otherwise floats q.
module bus_driver #(
    parameter int WIDTH = 8
) (
    input  logic             en_n,
    input  logic [WIDTH-1:0] d,
    output wire  [WIDTH-1:0] q
);

    assign q = en_n ? {WIDTH{1'bz}} : d;

endmodule

// File: rtl/program_counter.sv
// 16-bit program counter with abus fetch/jump access and mbus byte push/pop.
// Byte access over mbus is only functional when PC_BYTE_ACCESS_EN is defined.
module program_counter
    import program_counter_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire  [ADDR_W-1:0] abus,
    inout  wire  [DATA_W-1:0] mbus,
    input  logic              outn,
    input  logic              loadn,
    input  logic              incn,
    input  logic              outln,
    input  logic              outhn,
    input  logic              loadln,
    input  logic              loadhn
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic              lo_en_n;
    logic              hi_en_n;

    always_comb begin
        // NOTE: pc_next gets its hold value first so every path assigns it and no latch is inferred.
        pc_next = pc;
        if (!loadn) begin
            pc_next = abus;
`ifdef PC_BYTE_ACCESS_EN
        end else if (!loadln || !loadhn) begin
            if (!loadln) pc_next[DATA_W-1:0]      = mbus;
            if (!loadhn) pc_next[ADDR_W-1:DATA_W] = mbus;
`endif
        end else if (!incn) begin
            pc_next = pc + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment keeps the register update ordered correctly against other clocked readers.
        if (!reset) pc <= RESET_VECTOR;
        else        pc <= pc_next;
    end

`ifdef PC_BYTE_ACCESS_EN
    // Low byte wins when both byte outputs are requested, so mbus never sees two drivers.
    assign lo_en_n = outln;
    assign hi_en_n = outhn | ~outln;
`else
    logic unused_byte_access;
    assign unused_byte_access = &{1'b0, outln, outhn, loadln, loadhn, mbus};
    assign lo_en_n = 1'b1;
    assign hi_en_n = 1'b1;
`endif

    bus_driver #(.WIDTH(ADDR_W)) u_abus_drv (
        .en_n (outn),
        .d    (pc),
        .q    (abus)
    );

    bus_driver #(.WIDTH(DATA_W)) u_mbus_lo_drv (
        .en_n (lo_en_n),
        .d    (pc[DATA_W-1:0]),
        .q    (mbus)
    );

    bus_driver #(.WIDTH(DATA_W)) u_mbus_hi_drv (
        .en_n (hi_en_n),
        .d    (pc[ADDR_W-1:DATA_W]),
        .q    (mbus)
    );

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter; byte-access checks follow PC_BYTE_ACCESS_EN.
// Bus nets are pulled high, so a floating bus reads as all ones.
module tb_program_counter;

    logic clk = 1'b0;
    logic reset;
    logic outn, loadn, incn, outln, outhn, loadln, loadhn;

    tri1 [15:0] abus;
    tri1 [7:0]  mbus;

    logic [15:0] abus_drv;
    logic        abus_oe;
    logic [7:0]  mbus_drv;
    logic        mbus_oe;

    int n_tests = 0;
    int n_fail  = 0;

    assign abus = abus_oe ? abus_drv : 16'hzzzz;
    assign mbus = mbus_oe ? mbus_drv : 8'hzz;

    always #5 clk = ~clk;

    program_counter dut (
        .clk    (clk),
        .reset  (reset),
        .abus   (abus),
        .mbus   (mbus),
        .outn   (outn),
        .loadn  (loadn),
        .incn   (incn),
        .outln  (outln),
        .outhn  (outhn),
        .loadln (loadln),
        .loadhn (loadhn)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        outn = 1'b1; loadn = 1'b1; incn = 1'b1;
        outln = 1'b1; outhn = 1'b1; loadln = 1'b1; loadhn = 1'b1;
        abus_oe = 1'b0; mbus_oe = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observe pc through abus with no load/increment pending.
    task automatic peek_pc(input string tag, input logic [15:0] exp);
        idle();
        outn = 1'b0;
        #1;
        check(tag, abus, exp);
        outn = 1'b1;
    endtask

    task automatic load_pc(input logic [15:0] val);
        idle();
        abus_drv = val; abus_oe = 1'b1; loadn = 1'b0;
        step();
        idle();
    endtask

    initial begin
        idle();
        abus_drv = '0; mbus_drv = '0;
        reset = 1'b0;
        step();
        reset = 1'b1;

        peek_pc("reset_pc", 16'h0000);
        #1;
        check("reset_abus_z", abus, 16'hFFFF);
        check("reset_mbus_z", {8'h00, mbus}, 16'h00FF);

        load_pc(16'd64649);
        peek_pc("branch_load", 16'd64649);

        abus_drv = 16'd64649; abus_oe = 1'b1; loadn = 1'b0; incn = 1'b0;
        step();
        peek_pc("load_beats_inc", 16'd64649);

        load_pc(16'hFFFE);
        incn = 1'b0;
        step();
        peek_pc("inc_to_ffff", 16'hFFFF);
        incn = 1'b0;
        step();
        peek_pc("inc_wrap", 16'h0000);

        outn = 1'b0; incn = 1'b0;
        #1;
        check("fetch_old_pc", abus, 16'h0000);
        step();
        check("fetch_advanced", abus, 16'h0001);

        idle();
        outn = 1'b0; loadn = 1'b0;
        step();
        peek_pc("out_and_load", 16'h0001);

        load_pc(16'h4321);
        incn = 1'b0;
        step();
        reset = 1'b0; incn = 1'b0;
        step();
        reset = 1'b1;
        peek_pc("reset_over_inc", 16'h0000);

`ifdef PC_BYTE_ACCESS_EN
        load_pc(16'hFCE1);
        outln = 1'b0;
        #1;
        check("push_low", {8'h00, mbus}, 16'h00E1);
        outln = 1'b1; outhn = 1'b0;
        #1;
        check("push_high", {8'h00, mbus}, 16'h00FC);
        outln = 1'b0;
        #1;
        check("push_both_low_wins", {8'h00, mbus}, 16'h00E1);
        idle();

        mbus_drv = 8'h34; mbus_oe = 1'b1; loadln = 1'b0; incn = 1'b0;
        step();
        peek_pc("pop_low_no_inc", 16'hFC34);
        mbus_drv = 8'h12; mbus_oe = 1'b1; loadhn = 1'b0;
        step();
        peek_pc("pop_full", 16'h1234);

        load_pc(16'h0000);
        mbus_drv = 8'h34; mbus_oe = 1'b1; loadln = 1'b0;
        step();
        idle();
        reset = 1'b0;
        step();
        reset = 1'b1;
        peek_pc("pop_reset_mid", 16'h0000);
        mbus_drv = 8'h12; mbus_oe = 1'b1; loadhn = 1'b0;
        step();
        peek_pc("pop_high_after_reset", 16'h1200);

        mbus_drv = 8'hA5; mbus_oe = 1'b1; loadln = 1'b0; loadhn = 1'b0;
        step();
        peek_pc("pop_both_bytes", 16'hA5A5);
`else
        load_pc(16'h1234);
        outln = 1'b0;
        #1;
        check("off_outln_z", {8'h00, mbus}, 16'h00FF);
        outln = 1'b1; outhn = 1'b0;
        #1;
        check("off_outhn_z", {8'h00, mbus}, 16'h00FF);
        idle();

        mbus_drv = 8'h56; mbus_oe = 1'b1; loadln = 1'b0; loadhn = 1'b0;
        step();
        peek_pc("off_byte_load_ignored", 16'h1234);

        mbus_drv = 8'h56; mbus_oe = 1'b1; loadln = 1'b0; incn = 1'b0;
        step();
        peek_pc("off_inc_not_suppressed", 16'h1235);
`endif

        idle();
        #1;
        check("final_abus_z", abus, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/program_counter.md
# program_counter

16-bit program counter for the 8-bit CPU. It drives the current fetch address onto the 16-bit address bus (`abus`), increments after each fetch, and loads jump targets from `abus`, including the relative-branch result produced by the address calculator. It also exposes its low and high bytes on the 8-bit data bus (`mbus`) for CALL/RET return-address push and pop.

## Interface
- `RESET_VECTOR`, default 16'h0000, value loaded on reset.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low (0 = reset), sampled on the rising edge of `clk`.
- `abus`  inout  16  address bus; driven only when `outn`=0, otherwise high-Z.
- `mbus`  inout  8  data bus; driven only by byte output, otherwise high-Z.
- `outn`  in  1  active-low; drive PC onto `abus`.
- `loadn`  in  1  active-low; load PC from `abus`.
- `incn`  in  1  active-low; PC <= PC + 1.
- `outln` / `outhn`  in  1 each  active-low; drive PC[7:0] / PC[15:8] onto `mbus`.
- `loadln` / `loadhn`  in  1 each  active-low; load PC[7:0] / PC[15:8] from `mbus`.

## Operation
- Single 16-bit register `pc`. No FSM beyond the priority-resolved next-state.
- Next-state priority, highest first:
  - `reset`=0: `pc` <= `RESET_VECTOR`.
  - `loadn`=0: `pc` <= `abus`. Increment and byte loads are ignored.
  - byte loads: `loadln`=0 writes `pc[7:0]`, and `loadhn`=0 writes `pc[15:8]`, both from `mbus`. Both asserted writes the same byte to both halves. Any asserted byte load suppresses increment.
  - `incn`=0: `pc` <= `pc` + 1, modulo 2^16. 16'hFFFF wraps to 16'h0000 with no flag.
  - otherwise hold.
- `outn`=0 together with `loadn`=0 is legal. `abus` carries `pc`, the load rewrites the same value, and `pc` is unchanged.
- `outln`=0 together with `outhn`=0: low byte wins and the high byte is not driven, so `mbus` sees no self-contention.
- Outputs are combinational from `pc` and the enables. They are never driven from bus inputs in the same cycle.
- Reset asserted mid-sequence (for example between `loadln` and `loadhn` of a pop) discards the partial value. The next cycle reads `RESET_VECTOR`.

## Timing
- Reset value: `pc` = `RESET_VECTOR`; `abus` and `mbus` are high-Z after reset while the enables are deasserted.
- Load and increment latency: 1 clock. The new value is visible on `abus` or `mbus` immediately after the capturing edge.
- Output enable latency: 0 clocks (combinational tri-state).
- Bus inputs must be stable around the rising edge on which `loadn`, `loadln` or `loadhn` is low.
- Fetch pattern: `outn`=0 and `incn`=0 in the same cycle. `abus` shows the old PC during that cycle and the PC advances at the edge.

## Configuration
- `PC_BYTE_ACCESS_EN` defined:
  - `outln`, `outhn`, `loadln` and `loadhn` are functional as above.
- `PC_BYTE_ACCESS_EN` undefined:
  - the ports remain for interface stability but are ignored;
  - `mbus` is permanently high-Z;
  - the byte-load priority level is removed, so increment is never suppressed by it.

## Structure
- Shared include/package: address width (16), data width (8), and the default reset vector constant. These are shared with the address calculator and the stack pointer.
- One natural sub-module, `bus_driver`: a parameterised-width tri-state buffer (`en_n`, `d`, `q`). It is instantiated once for `abus` and twice for the `mbus` bytes.
- The next-state priority mux and the register stay in `program_counter`.

## Test plan
- Reset: `reset`=0 for one edge with `RESET_VECTOR`=16'h0000, then `outn`=0 → `abus`=16'h0000. With all enables high → `abus` and `mbus` are Z.
- Relative-branch load: external driver puts 16'd64649 on `abus`, `loadn`=0 for one edge, then `outn`=0 → `abus`=16'd64649. Also `loadn`=0 with `incn`=0 → still 64649, no increment.
- Increment and wrap: load 16'hFFFE, `incn`=0 for two edges → 16'hFFFF, then 16'h0000.
- Byte push: `pc`=16'hFCE1. `outln`=0 → `mbus`=8'hE1. `outhn`=0 → `mbus`=8'hFC. Both low → `mbus`=8'hE1.
- Byte pop with reset mid-op: `mbus`=8'h34 with `loadln`=0, then `mbus`=8'h12 with `loadhn`=0 → `pc`=16'h1234. Repeat with `reset`=0 between the two loads → `pc`=`RESET_VECTOR`, then the high-byte load alone gives 16'h12xx, where xx is the reset low byte.
- Macro off: rebuild without `PC_BYTE_ACCESS_EN`, assert `outln`=0 and `loadln`=0 → `mbus` stays Z and `pc` is unchanged.
